countdown_ctrl: RTL and testbench
=================================

// Module: countdown_ctrl
// PURPOSE
//  Sequencing controller for the 4-bit countdown timer datapath: owns the reload register,
//  tick prescaler, run/pause/alarm state machine and command priority.
//  Sits between front-panel command lines (start/stop/clear/load) and the counter/alarm display.
//  Replaces ad-hoc level handling with one defined command arbitration per cycle.
// PARAMETERS
//  WIDTH           4      counter width in bits
//  PRESET_DEFAULT  4'hF   reload/counter value after reset
//  TICK_DIV        1      clk cycles per decrement (>=1); 1 = decrement every RUN cycle
// PORTS
//  clk      in   1      single clock, rising edge
//  reset    in   1      asynchronous, active-high; all state to reset values immediately
//  start    in   1      level command: begin (IDLE/ALARM) or resume (PAUSE)
//  stop     in   1      level command: pause while RUN
//  clear    in   1      level command: abort to IDLE, counter := reload value
//  load     in   1      capture preset into reload register
//  preset   in   WIDTH  new reload value, sampled when load=1
//  counter  out  WIDTH  current count
//  alarm    out  1      count reached zero
//  running  out  1      1 in RUN
//  paused   out  1      1 in PAUSE
// BEHAVIOUR
//  Reset: state=IDLE, reload_q=counter=PRESET_DEFAULT, prescaler=0, alarm=running=paused=0.
//  Priority per cycle: reset > clear > stop > start; load is independent of start/stop.
//  IDLE : counter tracks reload_q. load -> reload_q:=preset, counter:=preset next cycle.
//         start -> RUN next edge; load+start same cycle -> count starts from preset.
//  RUN  : prescaler counts 0..TICK_DIV-1; tick when ==TICK_DIV-1; tick -> counter-1.
//         First decrement TICK_DIV cycles after entering RUN. load ignored.
//         stop -> PAUSE (counter and prescaler frozen, phase preserved).
//         tick with counter==1 -> counter:=0, state:=ALARM, alarm=1 from that edge.
//  PAUSE: start -> RUN, resumes with saved prescaler phase. load updates reload_q only.
//  ALARM: counter=0, alarm=1 held. start -> counter:=reload_q, RUN, prescaler:=0, alarm:=0.
//         load updates reload_q only.
//  clear (any state) -> IDLE, counter:=reload_q, prescaler:=0, alarm:=0, next edge.
//  stop with start in RUN -> PAUSE; stop in IDLE/PAUSE/ALARM has no effect.
//  reload_q==0 at start -> direct to ALARM next edge, no tick consumed.
//  Counter never wraps below 0; all arithmetic is WIDTH bits unsigned.
//  Outputs are registered; running/paused decode the state register.
// CONFIGURATION
//  COUNTDOWN_AUTO_RELOAD_EN defined: the tick reaching 0 keeps RUN and alarm pulses high for
//   exactly that one cycle. The next tick loads reload_q and counting continues. ALARM is entered
//   only when reload_q==0.
//  Undefined: behaviour as above; alarm latched in ALARM until start/clear/reset.
// STRUCTURE
//  Package countdown_pkg: typedef enum logic [1:0] cd_state_t {CD_IDLE, CD_RUN, CD_PAUSE,
//   CD_ALARM}; localparam CD_WIDTH_DEFAULT=4.
//  Sub-module countdown_tick_gen (TICK_DIV): en, clr inputs -> 1-cycle tick; holds phase when en=0.
//  Top holds FSM, reload_q, counter and alarm registers.
// TESTING  (WIDTH=4, PRESET_DEFAULT=15, TICK_DIV=1 unless noted)
//  1 reset, start 1 cycle -> counter 15..0 over 15 cycles; alarm=1 at 0 held 20+ cycles, running=0.
//  2 stop when counter==6 -> holds 6, paused=1 for 20 cycles; start -> 5 next cycle, running=1.
//  3 clear at counter==9 -> counter=15, IDLE, alarm=0 next edge; clear+start same cycle -> IDLE.
//  4 load preset=3 with start in IDLE -> 3,2,1,0 then alarm; load=1,preset=7 during RUN ignored.
//  5 TICK_DIV=4 -> decrement every 4 cycles; stop 2 cycles into period, resume -> next decrement
//    after 2 more RUN cycles.
//  6 COUNTDOWN_AUTO_RELOAD_EN, preset=2 -> 2,1,0(alarm 1 cycle),2,1,0...; async reset mid-run ->
//    counter=15, alarm=0 before the next clk edge.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer controller.
//   cd_state_t       : controller state encoding (idle, run, pause, alarm)
//   CD_WIDTH_DEFAULT : default counter width in bits
package countdown_pkg;

  typedef enum logic [1:0] {
    CD_IDLE,
    CD_RUN,
    CD_PAUSE,
    CD_ALARM
  } cd_state_t;

  localparam int unsigned CD_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/countdown_tick_gen.sv
// Tick prescaler for the countdown timer. Counts 0..TICK_DIV-1 while en is high and produces
// a one-cycle tick on the last count. The phase is held while en is low; clr restarts at 0.
// Ports:
//   clk   in  clock, rising edge
//   reset in  asynchronous active-high reset
//   en    in  advance the prescaler this cycle
//   clr   in  restart the prescaler at phase 0 (wins over en)
//   tick  out high for the cycle in which the prescaler is on its last count and enabled
module countdown_tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en && !clr && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Sequencing controller for the countdown timer: reload register, tick prescaler, and the
// idle/run/pause/alarm state machine with per-cycle command arbitration
// (reset > clear > stop > start; load is independent of start/stop).
// Build option: define COUNTDOWN_AUTO_RELOAD_EN to keep running after reaching zero; alarm then
// pulses for the one cycle the count reaches zero and the following tick reloads the count.
// Ports:
//   clk     in  clock, rising edge
//   reset   in  asynchronous active-high reset
//   start   in  begin counting (idle/alarm) or resume (pause)
//   stop    in  pause while running
//   clear   in  abort to idle, counter := reload value
//   load    in  capture preset into the reload register (ignored while running)
//   preset  in  new reload value
//   counter out current count (registered)
//   alarm   out count reached zero (registered)
//   running out state is RUN
//   paused  out state is PAUSE
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int unsigned      WIDTH          = CD_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] PRESET_DEFAULT = {WIDTH{1'b1}},
  parameter int unsigned      TICK_DIV       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] preset,
  output logic [WIDTH-1:0] counter,
  output logic             alarm,
  output logic             running,
  output logic             paused
);

  localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

  cd_state_t        state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic             alarm_q, alarm_d;
  logic             tick_en, tick_clr, tick;

  // The prescaler is frozen on a stop cycle so the pause keeps the exact phase, and restarts
  // whenever a fresh count begins from idle or alarm.
  assign tick_en  = (state_q == CD_RUN) && !clear && !stop;
  assign tick_clr = clear || (start && ((state_q == CD_IDLE) || (state_q == CD_ALARM)));

  countdown_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (tick_en),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    reload_d  = reload_q;
    counter_d = counter_q;
    alarm_d   = alarm_q;

    if (load && (state_q != CD_RUN)) begin
      reload_d = preset;
    end

    if (clear) begin
      state_d   = CD_IDLE;
      counter_d = reload_d;
      alarm_d   = 1'b0;
    end else begin
      unique case (state_q)
        CD_IDLE: begin
          // reload_d so that load+start in one cycle counts from the new preset
          counter_d = reload_d;
          if (start) begin
            if (reload_d == '0) begin
              state_d   = CD_ALARM;
              counter_d = '0;
              alarm_d   = 1'b1;
            end else begin
              state_d = CD_RUN;
            end
          end
        end

        CD_RUN: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          alarm_d = 1'b0;
`endif
          if (stop) begin
            state_d = CD_PAUSE;
          end else if (tick) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (counter_q == '0) begin
              if (reload_q == '0) begin
                state_d = CD_ALARM;
                alarm_d = 1'b1;
              end else begin
                counter_d = reload_q;
              end
            end else if (counter_q == CntOne) begin
              counter_d = '0;
              alarm_d   = 1'b1;
            end else begin
              counter_d = counter_q - CntOne;
            end
`else
            // <= guards against wrapping below zero
            if (counter_q <= CntOne) begin
              state_d   = CD_ALARM;
              counter_d = '0;
              alarm_d   = 1'b1;
            end else begin
              counter_d = counter_q - CntOne;
            end
`endif
          end
        end

        CD_PAUSE: begin
          if (start) begin
            state_d = CD_RUN;
          end
        end

        CD_ALARM: begin
          counter_d = '0;
          alarm_d   = 1'b1;
          if (start && (reload_d != '0)) begin
            state_d   = CD_RUN;
            counter_d = reload_d;
            alarm_d   = 1'b0;
          end
        end

        default: begin
          state_d = CD_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CD_IDLE;
      reload_q  <= PRESET_DEFAULT;
      counter_q <= PRESET_DEFAULT;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      reload_q  <= reload_d;
      counter_q <= counter_d;
      alarm_q   <= alarm_d;
    end
  end

  assign counter = counter_q;
  assign alarm   = alarm_q;
  assign running = (state_q == CD_RUN);
  assign paused  = (state_q == CD_PAUSE);

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl. Two instances share the command inputs: dut (TICK_DIV=1)
// and dut4 (TICK_DIV=4). Expected {counter, alarm, running, paused} are queued as stimulus is
// driven and popped after the following clock edge.
module tb_countdown_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stop, clear, load;
  logic [3:0] preset;
  logic [3:0] cnt1, cnt4;
  logic       al1, run1, pau1, al4, run4, pau4;

  typedef struct {
    string      tag;
    bit         which;
    logic [6:0] v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  countdown_ctrl #(
    .WIDTH(4), .PRESET_DEFAULT(4'hF), .TICK_DIV(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .load(load),
    .preset(preset), .counter(cnt1), .alarm(al1), .running(run1), .paused(pau1)
  );

  countdown_ctrl #(
    .WIDTH(4), .PRESET_DEFAULT(4'hF), .TICK_DIV(4)
  ) dut4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .load(load),
    .preset(preset), .counter(cnt4), .alarm(al4), .running(run4), .paused(pau4)
  );

  task automatic push_exp(input string tag, input bit which, input logic [3:0] c,
                          input logic a, input logic r, input logic p);
    exp_t e;
    e.tag   = tag;
    e.which = which;
    e.v     = {c, a, r, p};
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [6:0] obs;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=none expected=entry");
      return;
    end
    e   = sb.pop_front();
    obs = e.which ? {cnt4, al4, run4, pau4} : {cnt1, al1, run1, pau1};
    assert (obs === e.v)
    else begin
      bad++;
      $error("FAIL %s observed cnt=%0d al=%b run=%b pau=%b expected cnt=%0d al=%b run=%b pau=%b",
             e.tag, obs[6:3], obs[2], obs[1], obs[0], e.v[6:3], e.v[2], e.v[1], e.v[0]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input bit which, input logic [3:0] c,
                      input logic a, input logic r, input logic p);
    push_exp(tag, which, c, a, r, p);
    cyc();
    check_out();
  endtask

  // Called at 1 time unit after an edge; the reset pulse finishes well before the next edge.
  task automatic pulse_reset();
    #1 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0; preset = 4'd0;
    #3;
    push_exp("reset_state", 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
    check_out();
    cyc();
    reset = 1'b0;

    // 1: full countdown from 15, alarm latched
    start = 1'b1;
    step("t1_start", 1'b0, 4'd15, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    for (int k = 14; k >= 1; k--) step("t1_count", 1'b0, 4'(k), 1'b0, 1'b1, 1'b0);
    step("t1_zero", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step("t1_alarm_hold", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

    // 2: pause at 6 and resume
    clear = 1'b1;
    step("t2_clear_alarm", 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    start = 1'b1;
    step("t2_start", 1'b0, 4'd15, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    for (int k = 14; k >= 6; k--) step("t2_count", 1'b0, 4'(k), 1'b0, 1'b1, 1'b0);
    stop = 1'b1;
    step("t2_stop", 1'b0, 4'd6, 1'b0, 1'b0, 1'b1);
    stop = 1'b0;
    for (int k = 0; k < 19; k++) step("t2_paused", 1'b0, 4'd6, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    step("t2_resume", 1'b0, 4'd6, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    step("t2_resume_dec", 1'b0, 4'd5, 1'b0, 1'b1, 1'b0);

    // 3: clear at 9, then clear+start together stays idle
    clear = 1'b1;
    step("t3_clear", 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    start = 1'b1;
    step("t3_start", 1'b0, 4'd15, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    for (int k = 14; k >= 9; k--) step("t3_count", 1'b0, 4'(k), 1'b0, 1'b1, 1'b0);
    clear = 1'b1;
    step("t3_clear_at9", 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step("t3_clear_start", 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
    clear = 1'b0; start = 1'b0;
    step("t3_idle", 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);

    // 4: load+start, load ignored while running, zero reload goes straight to alarm
    load = 1'b1; preset = 4'd3; start = 1'b1;
    step("t4_load_start", 1'b0, 4'd3, 1'b0, 1'b1, 1'b0);
    start = 1'b0; preset = 4'd7;
    step("t4_run_load_ign", 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
    step("t4_run_load_ign", 1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
    load = 1'b0;
    step("t4_alarm", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    clear = 1'b1;
    step("t4_reload_kept", 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    load = 1'b1; preset = 4'd0;
    step("t4_load_zero", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    load = 1'b0; start = 1'b1;
    step("t4_zero_start", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t4_zero_hold", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

    // 5: TICK_DIV=4 with pause mid-period (dut4)
    pulse_reset();
    start = 1'b1;
    step("t5_start", 1'b1, 4'd15, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    for (int k = 0; k < 3; k++) step("t5_prescale", 1'b1, 4'd15, 1'b0, 1'b1, 1'b0);
    step("t5_first_dec", 1'b1, 4'd14, 1'b0, 1'b1, 1'b0);
    step("t5_phase1", 1'b1, 4'd14, 1'b0, 1'b1, 1'b0);
    step("t5_phase2", 1'b1, 4'd14, 1'b0, 1'b1, 1'b0);
    stop = 1'b1;
    step("t5_stop", 1'b1, 4'd14, 1'b0, 1'b0, 1'b1);
    stop = 1'b0;
    for (int k = 0; k < 2; k++) step("t5_paused", 1'b1, 4'd14, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    step("t5_resume", 1'b1, 4'd14, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    step("t5_resume_p3", 1'b1, 4'd14, 1'b0, 1'b1, 1'b0);
    step("t5_resume_dec", 1'b1, 4'd13, 1'b0, 1'b1, 1'b0);

    // 6: auto-reload sequence, or a plain short run, then async reset mid-run
    pulse_reset();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    load = 1'b1; preset = 4'd2; start = 1'b1;
    step("t6_start", 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
    load = 1'b0; start = 1'b0;
    for (int n = 0; n < 2; n++) begin
      step("t6_one", 1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
      step("t6_zero_pulse", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      step("t6_reload", 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
    end
`else
    start = 1'b1;
    step("t6_start", 1'b0, 4'd15, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    step("t6_run", 1'b0, 4'd14, 1'b0, 1'b1, 1'b0);
    step("t6_run", 1'b0, 4'd13, 1'b0, 1'b1, 1'b0);
`endif
    #2 reset = 1'b1;
    #1;
    push_exp("t6_async_reset", 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
    check_out();
    push_exp("t6_async_reset4", 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
    check_out();
    cyc();
    reset = 1'b0;
    step("t6_after_reset", 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);

    total++;
    assert (sb.size() == 0)
    else begin
      bad++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
